// File: rtl/seq_det_pkg.sv
// Shared types and default parameters for the bit-serial sequence-detection controller.
package seq_det_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned PAT_W_DEF  = 4;
    localparam int unsigned CNT_W_DEF  = 8;

    localparam logic [PAT_W_DEF-1:0] PAT_RST_DEF = 4'b1011;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/seq_det_ctrl_pat_match.sv
// Sequence matcher: bit history, saturating fill count and hit detection.
// SEQ_DET_OVERLAP_EN defined keeps history after a hit (overlapping detection).
module pat_match
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_vld,
    input  logic [PAT_W-1:0] pattern,
    input  logic             clr,
    output logic             hit
);

    localparam int unsigned       FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist_q, hist_d, hist_shift;
    logic [FILL_W-1:0] fill_q, fill_d, fill_inc;

    always_comb begin
        hist_shift = {hist_q[PAT_W-2:0], bit_in};
        fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
        // Partial history never matches: the fill count must be full.
        hit        = bit_vld && !clr && (fill_inc == FILL_FULL) && (hist_shift == pattern);
        hist_d     = hist_q;
        fill_d     = fill_q;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (bit_vld) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
`ifdef SEQ_DET_OVERLAP_EN
`else
            if (hit) begin
                fill_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Byte handshake, MSB-first serializer, pattern config and saturating match counter.
// Overlap behaviour of the matcher is selected by SEQ_DET_OVERLAP_EN.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned      DATA_W  = DATA_W_DEF,
    parameter int unsigned      PAT_W   = PAT_W_DEF,
    parameter int unsigned      CNT_W   = CNT_W_DEF,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_RST_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic              cfg_load,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              busy,
    output logic              match,
    output logic [CNT_W-1:0]  match_cnt,
    input  logic              cnt_clr
);

    localparam int unsigned      IDX_W   = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [PAT_W-1:0]  pattern_q, pattern_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              match_q, match_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic bit_vld_c, bit_in_c, clr_c, hit_c;

    pat_match #(
        .PAT_W (PAT_W)
    ) u_pat_match (
        .clk     (clk),
        .rst     (rst),
        .bit_in  (bit_in_c),
        .bit_vld (bit_vld_c),
        .pattern (pattern_q),
        .clr     (clr_c),
        .hit     (hit_c)
    );

    // Handshake FSM, serializer and counter next-state
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        idx_d      = idx_q;
        pattern_d  = pattern_q;
        in_ready_d = in_ready_q;
        busy_d     = busy_q;
        bit_vld_c  = (state_q == ST_SHIFT);
        bit_in_c   = shreg_q[idx_q];
        clr_c      = (state_q == ST_IDLE) && cfg_load;

        case (state_q)
            ST_IDLE: begin
                if (cfg_load) begin
                    pattern_d = cfg_pattern;
                end
                if (in_valid) begin
                    shreg_d    = in_data;
                    idx_d      = IDX_W'(DATA_W - 1);
                    state_d    = ST_SHIFT;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (idx_q == '0) begin
                    state_d    = ST_IDLE;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
        endcase

        match_d = hit_c;
        // Clear wins over a coincident hit; the match pulse still fires.
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (hit_c && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            idx_q      <= '0;
            pattern_q  <= PAT_RST;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            match_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            idx_q      <= idx_d;
            pattern_q  <= pattern_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            match_q    <= match_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign match     = match_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed scenarios plus random traffic vs a bit-stream model.
module tb_seq_det_ctrl;

    localparam int DW = 8;
    localparam int PW = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [PW-1:0] cfg_pattern = 4'b1011;
    logic          cfg_load = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready, busy, match;
    logic [CW-1:0] match_cnt;
    logic          cnt_clr = 1'b0;

    always #5 clk = ~clk;

    seq_det_ctrl #(
        .DATA_W  (DW),
        .PAT_W   (PW),
        .CNT_W   (CW),
        .PAT_RST (4'b1011)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_pattern (cfg_pattern),
        .cfg_load    (cfg_load),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .busy        (busy),
        .match       (match),
        .match_cnt   (match_cnt),
        .cnt_clr     (cnt_clr)
    );

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int match_edges[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) edge_n <= edge_n + 1;

    // Behavioural model: bits remaining in the current byte and a plain bit-history integer.
    int m_left = 0, m_byte = 0, m_hist = 0, m_fill = 0, m_pat = 0, m_cnt = 0, m_b = 0;
    bit m_match = 0, m_hit = 0, model_ok = 0;

    always @(posedge clk) begin
        if (!rst) begin
            m_left = 0; m_hist = 0; m_fill = 0; m_pat = 'b1011; m_cnt = 0; m_match = 0;
            model_ok = 1;
        end else if (model_ok) begin
            m_hit = 0;
            if (m_left > 0) begin
                m_b    = (m_byte >> (m_left - 1)) & 1;
                m_left = m_left - 1;
                m_hist = ((m_hist << 1) | m_b) & ((1 << PW) - 1);
                if (m_fill < PW) m_fill = m_fill + 1;
                if (m_fill == PW && m_hist == m_pat) begin
                    m_hit = 1;
`ifndef SEQ_DET_OVERLAP_EN
                    m_fill = 0;
`endif
                end
            end else begin
                if (cfg_load) begin
                    m_pat = int'(cfg_pattern); m_hist = 0; m_fill = 0;
                end
                if (in_valid) begin
                    m_byte = int'(in_data); m_left = DW;
                end
            end
            if (cnt_clr) m_cnt = 0;
            else if (m_hit && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
            m_match = m_hit;
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle
    always @(negedge clk) begin
        if (model_ok) begin
            chk("in_ready", int'(in_ready), int'(m_left == 0));
            chk("busy", int'(busy), int'(m_left > 0));
            chk("match", int'(match), int'(m_match));
            chk("match_cnt", int'(match_cnt), m_cnt);
        end
        if (match === 1'b1) match_edges.push_back(edge_n);
    end

    task automatic send_byte(input logic [DW-1:0] d, output int k);
        bit rdy;
        bit acc;
        acc = 0;
        in_data  = d;
        in_valid = 1'b1;
        for (int t = 0; t < 40 && !acc; t++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) acc = 1;
        end
        if (!acc) chk("accept_timeout", 0, 1);
        k = edge_n;
        in_valid = 1'b0;
    endtask

    task automatic finish_byte(input int k);
        for (int t = 0; t < 40 && edge_n < k + DW; t++) @(negedge clk);
        chk("ready_back", int'(in_ready), 1);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
    endtask

    task automatic load_pat(input logic [PW-1:0] p);
        @(negedge clk);
        cfg_pattern = p;
        cfg_load    = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k1, k2;

        // Reset values
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_match", int'(match), 0);
        chk("rst_cnt", int'(match_cnt), 0);
        rst = 1'b1;

        // 0xB0 with default pattern 1011: hit after edge k+4
        match_edges.delete();
        send_byte(8'hB0, k);
        chk("b0_busy_after_accept", int'(busy), 1);
        finish_byte(k);
        chk("b0_hits", match_edges.size(), 1);
        if (match_edges.size() > 0) chk("b0_offset", match_edges[0] - k, 4);
        chk("b0_cnt", int'(match_cnt), 1);
        chk("b0_model_cnt", m_cnt, 1);

        // 0x5B: overlap gives hits at 5 and 8, otherwise only at 5
        pulse_clr();
        match_edges.delete();
        send_byte(8'h5B, k);
        finish_byte(k);
`ifdef SEQ_DET_OVERLAP_EN
        chk("5b_hits", match_edges.size(), 2);
        if (match_edges.size() > 1) chk("5b_offset2", match_edges[1] - k, 8);
        chk("5b_cnt", int'(match_cnt), 2);
        chk("5b_model_cnt", m_cnt, 2);
`else
        chk("5b_hits", match_edges.size(), 1);
        chk("5b_cnt", int'(match_cnt), 1);
        chk("5b_model_cnt", m_cnt, 1);
`endif
        if (match_edges.size() > 0) chk("5b_offset1", match_edges[0] - k, 5);

        // Back-to-back 0x01, 0x60: hit spans the byte boundary
        pulse_clr();
        load_pat(4'b1011);
        match_edges.delete();
        send_byte(8'h01, k1);
        send_byte(8'h60, k2);
        chk("b2b_spacing", k2 - k1, DW + 1);
        finish_byte(k2);
        chk("b2b_hits", match_edges.size(), 1);
        if (match_edges.size() > 0) chk("b2b_offset", match_edges[0] - k2, 3);
        chk("b2b_cnt", int'(match_cnt), 1);

        // cfg_load while busy is ignored
        pulse_clr();
        match_edges.delete();
        send_byte(8'hB0, k);
        cfg_pattern = 4'b0110;
        cfg_load    = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        finish_byte(k);
        chk("busy_cfg_hits", match_edges.size(), 1);
        if (match_edges.size() > 0) chk("busy_cfg_offset", match_edges[0] - k, 4);
        chk("busy_cfg_cnt", int'(match_cnt), 1);

        // cfg_load and byte on the same idle edge: new pattern 0110 applies
        pulse_clr();
        match_edges.delete();
        cfg_pattern = 4'b0110;
        cfg_load    = 1'b1;
        send_byte(8'h60, k);
        cfg_load = 1'b0;
        finish_byte(k);
        chk("idle_cfg_hits", match_edges.size(), 1);
        if (match_edges.size() > 0) chk("idle_cfg_offset", match_edges[0] - k, 4);
        chk("idle_cfg_cnt", int'(match_cnt), 1);

        // Saturation: 130 bytes of 0xBB give two hits each
        pulse_clr();
        load_pat(4'b1011);
        for (int i = 0; i < 130; i++) send_byte(8'hBB, k);
        finish_byte(k);
        chk("sat_cnt", int'(match_cnt), 255);
        chk("sat_model_cnt", m_cnt, 255);

        // cnt_clr coincident with a hit
        send_byte(8'hB0, k);
        repeat (3) @(posedge clk);
        #1;
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("clr_hit_match", int'(match), 1);
        chk("clr_hit_cnt", int'(match_cnt), 0);
        finish_byte(k);

        // Reset mid-shift discards the byte
        load_pat(4'b1011);
        match_edges.delete();
        send_byte(8'hB0, k);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_ready", int'(in_ready), 1);
        chk("rst_mid_cnt", int'(match_cnt), 0);
        chk("rst_mid_match", int'(match), 0);
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_mid_no_hit", match_edges.size(), 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            in_valid    = 1'($urandom_range(0, 1));
            in_data     = 8'($urandom);
            cnt_clr     = ($urandom_range(0, 31) == 0);
            cfg_load    = ($urandom_range(0, 15) == 0);
            cfg_pattern = 4'($urandom);
            rst         = ($urandom_range(0, 499) != 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
        cfg_load = 1'b0;
        rst      = 1'b1;
        repeat (12) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
